// File: rtl/sccb_responder_if.sv
// SCCB line and register-file signals between the responder (slave) and its environment (master).
// No clocking in the interface; all timing lives in the responder.
interface sccb_responder_if;
    logic       sioc_in;
    logic       siod_in;
    logic       siod_oe;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    modport slave (
        input  sioc_in, siod_in, rd_data,
        output siod_oe, wr_en, wr_addr, wr_data, rd_addr, busy
    );

    modport master (
        output sioc_in, siod_in, rd_data,
        input  siod_oe, wr_en, wr_addr, wr_data, rd_addr, busy
    );
endinterface

// File: rtl/sccb_responder.sv
// SCCB target: decodes ID/SUB/WDATA writes and ID+RDATA reads; define SCCB_ACK_DRIVE_EN to pull SIOD low in ACK slots.
// Decisions 3 clk after raw inputs, siod_oe 1 clk after a synced SIOC fall; no backpressure, wr_en is a one-cycle strobe.
module sccb_responder #(
    parameter int         CLK_FREQ       = 25_000_000,
    parameter int         SCCB_FREQ      = 100_000,
    parameter logic [7:0] DEVICE_ADDR    = 8'h42,
    parameter int         TIMEOUT_CYCLES = 4 * CLK_FREQ / SCCB_FREQ
) (
    input  logic               clk,
    input  logic               rst_n,
    sccb_responder_if.slave    bus
);

    localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] READ_ADDR = DEVICE_ADDR | 8'h01;
`ifdef SCCB_ACK_DRIVE_EN
    localparam logic       ACK_DRIVE = 1'b1;
`else
    localparam logic       ACK_DRIVE = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE
    } state_t;

    state_t         state, state_d;
    logic           sioc_ff, sioc_s, sioc_p;
    logic           siod_ff, siod_s, siod_p;
    logic [3:0]     cnt, cnt_d;
    logic [7:0]     sr, sr_d;
    logic           oe, oe_d;
    logic           is_read, is_read_d;
    logic           wr_en_q, wr_en_d;
    logic [7:0]     wr_addr_q, wr_addr_d;
    logic [7:0]     wr_data_q, wr_data_d;
    logic [7:0]     rd_addr_q, rd_addr_d;
    logic [TW-1:0]  tcnt, tcnt_d;

    logic           sioc_rise, sioc_fall, start_c, stop_c, timeout_c;
    logic [7:0]     byte_in;

    assign sioc_rise = sioc_s & ~sioc_p;
    assign sioc_fall = ~sioc_s & sioc_p;
    assign start_c   = sioc_s & siod_p & ~siod_s;
    // Stop uses the current SIOC level, so a joint SIOC/SIOD release counts as stop.
    assign stop_c    = sioc_s & ~siod_p & siod_s;
    assign timeout_c = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign byte_in   = {sr[6:0], siod_s};

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sr_d      = sr;
        oe_d      = oe;
        is_read_d = is_read;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;

        if (state == IDLE || sioc_rise || sioc_fall || start_c || stop_c)
            tcnt_d = '0;
        else
            tcnt_d = tcnt + 1'b1;

        if (start_c) begin
            state_d = ID;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_c || timeout_c) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state)
                ID, SUB, WDATA: begin
                    if (sioc_rise) begin
                        sr_d  = byte_in;
                        cnt_d = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_d = 4'd0;
                            if (state == ID) begin
                                if (byte_in == DEVICE_ADDR) begin
                                    state_d   = ID_ACK;
                                    is_read_d = 1'b0;
                                end else if (byte_in == READ_ADDR) begin
                                    state_d   = ID_ACK;
                                    is_read_d = 1'b1;
                                end else begin
                                    state_d   = IGNORE;
                                end
                            end else if (state == SUB) begin
                                rd_addr_d = byte_in;
                                state_d   = SUB_ACK;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = rd_addr_q;
                                wr_data_d = byte_in;
                                state_d   = WDATA_ACK;
                            end
                        end
                    end
                end
                ID_ACK, SUB_ACK, WDATA_ACK: begin
                    // First fall opens the ACK slot, second fall closes it.
                    if (sioc_fall) begin
                        if (cnt == 4'd0) begin
                            oe_d  = ACK_DRIVE;
                            cnt_d = 4'd1;
                        end else begin
                            cnt_d = 4'd0;
                            oe_d  = 1'b0;
                            if (state == ID_ACK) begin
                                if (is_read) begin
                                    state_d = RDATA;
                                    sr_d    = {bus.rd_data[6:0], 1'b0};
                                    oe_d    = ~bus.rd_data[7];
                                    cnt_d   = 4'd1;
                                end else begin
                                    state_d = SUB;
                                end
                            end else if (state == SUB_ACK) begin
                                state_d = WDATA;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (sioc_fall) begin
                        if (cnt == 4'd8) begin
                            state_d = RD_NA;
                            oe_d    = 1'b0;
                        end else begin
                            oe_d  = ~sr[7];
                            sr_d  = {sr[6:0], 1'b0};
                            cnt_d = cnt + 4'd1;
                        end
                    end
                end
                RD_NA: begin
                    if (sioc_fall)
                        state_d = IGNORE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sioc_ff   <= 1'b1;
            sioc_s    <= 1'b1;
            sioc_p    <= 1'b1;
            siod_ff   <= 1'b1;
            siod_s    <= 1'b1;
            siod_p    <= 1'b1;
            state     <= IDLE;
            cnt       <= 4'd0;
            sr        <= 8'd0;
            oe        <= 1'b0;
            is_read   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 8'd0;
            rd_addr_q <= 8'd0;
            tcnt      <= '0;
        end else begin
            sioc_ff   <= bus.sioc_in;
            sioc_s    <= sioc_ff;
            sioc_p    <= sioc_s;
            siod_ff   <= bus.siod_in;
            siod_s    <= siod_ff;
            siod_p    <= siod_s;
            state     <= state_d;
            cnt       <= cnt_d;
            sr        <= sr_d;
            oe        <= oe_d;
            is_read   <= is_read_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            tcnt      <= tcnt_d;
        end
    end

    assign bus.siod_oe = oe;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: bit-banged SCCB master, open-drain SIOD, register-file model and write scoreboard.
module tb_sccb_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sccb_responder_if bus();

    sccb_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef SCCB_ACK_DRIVE_EN
    localparam logic ACK_LINE = 1'b0;
`else
    localparam logic ACK_LINE = 1'b1;
`endif

    logic        sioc_m = 1'b1;
    logic        siod_m = 1'b1;
    logic [7:0]  mem       [256];
    logic [7:0]  model_mem [256];
    logic [7:0]  cur_sub;
    logic [15:0] got_wr [$];
    logic        oe_seen;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          hp    = 10;

    assign bus.sioc_in = sioc_m;
    assign bus.siod_in = siod_m & ~bus.siod_oe;
    assign bus.rd_data = mem[bus.rd_addr];

    // Register-file side: capture strobes and apply them to the memory the DUT reads.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            got_wr.push_back({bus.wr_addr, bus.wr_data});
            mem[bus.wr_addr] = bus.wr_data;
        end
        if (bus.siod_oe === 1'b1) oe_seen = 1'b1;
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_bit(input logic b, output logic line);
        wclk(hp / 2);      siod_m = b;
        wclk(hp - hp / 2); sioc_m = 1'b1;
        wclk(hp / 2);      line = bus.siod_in;
        wclk(hp - hp / 2); sioc_m = 1'b0;
    endtask

    task automatic m_byte(input logic [7:0] b, output logic [7:0] rb, output logic ack);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            m_bit(b[i], l);
            rb[i] = l;
        end
        m_bit(1'b1, ack);
    endtask

    task automatic m_start;
        wclk(hp); siod_m = 1'b0;
        wclk(hp); sioc_m = 1'b0;
    endtask

    task automatic m_stop;
        wclk(hp / 2);      siod_m = 1'b0;
        wclk(hp - hp / 2); sioc_m = 1'b1;
        wclk(hp);          siod_m = 1'b1;
        wclk(hp);
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        wclk(3);
        rst_n = 1'b1;
        wclk(2);
        n_cmp++; if (bus.siod_oe !== 1'b0) begin n_bad++; $display("FAIL rst_siod_oe got=%b exp=0", bus.siod_oe); end
        n_cmp++; if (bus.wr_en   !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en got=%b exp=0", bus.wr_en); end
        n_cmp++; if (bus.wr_addr !== 8'h00) begin n_bad++; $display("FAIL rst_wr_addr got=%h exp=00", bus.wr_addr); end
        n_cmp++; if (bus.wr_data !== 8'h00) begin n_bad++; $display("FAIL rst_wr_data got=%h exp=00", bus.wr_data); end
        n_cmp++; if (bus.rd_addr !== 8'h00) begin n_bad++; $display("FAIL rst_rd_addr got=%h exp=00", bus.rd_addr); end
        n_cmp++; if (bus.busy    !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        cur_sub = 8'h00;
    endtask

    task automatic test_write_100k;
        logic [7:0]  rb;
        logic        ack;
        logic [15:0] w;
        hp = 125;
        got_wr.delete();
        m_start;
        m_byte(8'h42, rb, ack);
        n_cmp++; if (ack !== ACK_LINE) begin n_bad++; $display("FAIL w100k_ack_id got=%b exp=%b", ack, ACK_LINE); end
        m_byte(8'h12, rb, ack);
        n_cmp++; if (ack !== ACK_LINE) begin n_bad++; $display("FAIL w100k_ack_sub got=%b exp=%b", ack, ACK_LINE); end
        m_byte(8'h80, rb, ack);
        n_cmp++; if (ack !== ACK_LINE) begin n_bad++; $display("FAIL w100k_ack_data got=%b exp=%b", ack, ACK_LINE); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL w100k_busy_pre_stop got=%b exp=1", bus.busy); end
        m_stop;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL w100k_busy_post_stop got=%b exp=0", bus.busy); end
        n_cmp++; if (got_wr.size() != 1) begin n_bad++; $display("FAIL w100k_wr_count got=%0d exp=1", got_wr.size()); end
        w = (got_wr.size() > 0) ? got_wr[0] : 16'hxxxx;
        n_cmp++; if (w !== 16'h1280) begin n_bad++; $display("FAIL w100k_wr_addr_data got=%h exp=1280", w); end
        n_cmp++; if ({bus.wr_addr, bus.wr_data} !== 16'h1280) begin n_bad++; $display("FAIL w100k_wr_hold got=%h exp=1280", {bus.wr_addr, bus.wr_data}); end
        model_mem[8'h12] = 8'h80;
        cur_sub = 8'h12;
        got_wr.delete();
    endtask

    task automatic test_wrong_id;
        logic [7:0] rb;
        logic       ack;
        logic [7:0] bytes [3];
        hp = 10;
        bytes[0] = 8'h40; bytes[1] = 8'h12; bytes[2] = 8'h80;
        got_wr.delete();
        oe_seen = 1'b0;
        m_start;
        for (int k = 0; k < 3; k++) begin
            m_byte(bytes[k], rb, ack);
            n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL wrongid_ack%0d got=%b exp=1", k, ack); end
        end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL wrongid_busy_ignore got=%b exp=1", bus.busy); end
        m_stop;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL wrongid_busy_stop got=%b exp=0", bus.busy); end
        n_cmp++; if (got_wr.size() != 0) begin n_bad++; $display("FAIL wrongid_wr_count got=%0d exp=0", got_wr.size()); end
        n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL wrongid_oe_seen got=%b exp=0", oe_seen); end
    endtask

    task automatic test_read;
        logic [7:0] rb;
        logic       ack;
        hp = 10;
        mem[8'h0A] = 8'hA5;
        model_mem[8'h0A] = 8'hA5;
        m_start;
        m_byte(8'h42, rb, ack);
        n_cmp++; if (ack !== ACK_LINE) begin n_bad++; $display("FAIL read_setup_ack_id got=%b exp=%b", ack, ACK_LINE); end
        m_byte(8'h0A, rb, ack);
        n_cmp++; if (ack !== ACK_LINE) begin n_bad++; $display("FAIL read_setup_ack_sub got=%b exp=%b", ack, ACK_LINE); end
        m_stop;
        cur_sub = 8'h0A;
        n_cmp++; if (bus.rd_addr !== 8'h0A) begin n_bad++; $display("FAIL read_rd_addr got=%h exp=0a", bus.rd_addr); end
        m_start;
        m_byte(8'h43, rb, ack);
        n_cmp++; if (ack !== ACK_LINE) begin n_bad++; $display("FAIL read_ack_id got=%b exp=%b", ack, ACK_LINE); end
        m_byte(8'hFF, rb, ack);
        n_cmp++; if (rb !== 8'hA5) begin n_bad++; $display("FAIL read_data got=%h exp=a5", rb); end
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL read_na_slot got=%b exp=1", ack); end
        m_stop;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL read_busy_stop got=%b exp=0", bus.busy); end
    endtask

    task automatic test_simul_release;
        logic [7:0] rb;
        logic       ack;
        hp = 10;
        got_wr.delete();
        m_start;
        m_byte(8'h42, rb, ack);
        m_byte(8'h3C, rb, ack);
        wclk(hp / 2); siod_m = 1'b0;
        wclk(hp);
        sioc_m = 1'b1;
        siod_m = 1'b1;
        wclk(4);
        cur_sub = 8'h3C;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL simrel_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.rd_addr !== 8'h3C) begin n_bad++; $display("FAIL simrel_rd_addr got=%h exp=3c", bus.rd_addr); end
        wclk(hp);
        n_cmp++; if (got_wr.size() != 0) begin n_bad++; $display("FAIL simrel_wr_count got=%0d exp=0", got_wr.size()); end
    endtask

    task automatic test_timeout;
        logic [7:0]  rb;
        logic        ack, l;
        logic [7:0]  d;
        logic [15:0] w;
        hp = 10;
        got_wr.delete();
        m_start;
        m_byte(8'h42, rb, ack);
        for (int i = 0; i < 4; i++) m_bit(1'b1, l);
        wclk(900);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL tmo_busy_before got=%b exp=1", bus.busy); end
        wclk(150);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL tmo_busy_after got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.siod_oe !== 1'b0) begin n_bad++; $display("FAIL tmo_siod_oe got=%b exp=0", bus.siod_oe); end
        siod_m = 1'b1;
        wclk(hp);
        sioc_m = 1'b1;
        wclk(hp);
        d = 8'($urandom);
        m_start;
        m_byte(8'h42, rb, ack);
        m_byte(8'h12, rb, ack);
        m_byte(d, rb, ack);
        m_stop;
        n_cmp++; if (got_wr.size() != 1) begin n_bad++; $display("FAIL tmo_recover_count got=%0d exp=1", got_wr.size()); end
        w = (got_wr.size() > 0) ? got_wr[0] : 16'hxxxx;
        n_cmp++; if (w !== {8'h12, d}) begin n_bad++; $display("FAIL tmo_recover_write got=%h exp=%h", w, {8'h12, d}); end
        model_mem[8'h12] = d;
        cur_sub = 8'h12;
        got_wr.delete();
    endtask

    task automatic test_reset_mid_read;
        logic [7:0] rb;
        logic       ack, l;
        hp = 10;
        mem[8'h5C] = 8'h37;
        model_mem[8'h5C] = 8'h37;
        m_start;
        m_byte(8'h42, rb, ack);
        m_byte(8'h5C, rb, ack);
        m_stop;
        m_start;
        m_byte(8'h43, rb, ack);
        for (int i = 0; i < 4; i++) m_bit(1'b1, l);
        wclk(6);
        n_cmp++; if (bus.siod_oe !== 1'b1) begin n_bad++; $display("FAIL rmr_driving_bit3 got=%b exp=1", bus.siod_oe); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.siod_oe !== 1'b0) begin n_bad++; $display("FAIL rmr_siod_oe got=%b exp=0", bus.siod_oe); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmr_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.rd_addr !== 8'h00) begin n_bad++; $display("FAIL rmr_rd_addr got=%h exp=00", bus.rd_addr); end
        sioc_m = 1'b1;
        siod_m = 1'b1;
        wclk(3);
        rst_n = 1'b1;
        cur_sub = 8'h00;
        wclk(5);
    endtask

    task automatic test_random;
        logic [7:0]  id, rb;
        logic [7:0]  p [4];
        logic        ack;
        int          nb, r, exp_n;
        logic [15:0] exp_w, w;
        for (int t = 0; t < 14; t++) begin
            hp = $urandom_range(5, 12);
            r  = $urandom_range(0, 9);
            if (r < 4)      id = 8'h42;
            else if (r < 7) id = 8'h43;
            else begin
                id = 8'($urandom);
                if (id[7:1] == 7'h21) id = 8'h5A;
            end
            nb = $urandom_range(2, 4);
            for (int k = 0; k < 4; k++) p[k] = 8'($urandom);
            exp_n = 0;
            exp_w = 16'h0000;
            got_wr.delete();
            oe_seen = 1'b0;
            m_start;
            m_byte(id, rb, ack);
            n_cmp++; if (ack !== ((id == 8'h42 || id == 8'h43) ? ACK_LINE : 1'b1)) begin n_bad++; $display("FAIL rnd%0d_ack_id id=%h got=%b", t, id, ack); end
            if (id == 8'h43) begin
                m_byte(8'hFF, rb, ack);
                n_cmp++; if (rb !== model_mem[cur_sub]) begin n_bad++; $display("FAIL rnd%0d_read sub=%h got=%h exp=%h", t, cur_sub, rb, model_mem[cur_sub]); end
                n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_na got=%b exp=1", t, ack); end
            end else begin
                for (int k = 1; k < nb; k++) begin
                    m_byte(p[k], rb, ack);
                    n_cmp++; if (ack !== ((id == 8'h42 && k <= 2) ? ACK_LINE : 1'b1)) begin n_bad++; $display("FAIL rnd%0d_ack_byte%0d got=%b", t, k, ack); end
                end
            end
            m_stop;
            n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_busy got=%b exp=0", t, bus.busy); end
            if (id == 8'h42) begin
                cur_sub = p[1];
                if (nb >= 3) begin
                    model_mem[p[1]] = p[2];
                    exp_n = 1;
                    exp_w = {p[1], p[2]};
                end
            end
            n_cmp++; if (got_wr.size() != exp_n) begin n_bad++; $display("FAIL rnd%0d_wr_count got=%0d exp=%0d", t, got_wr.size(), exp_n); end
            if (exp_n == 1) begin
                w = (got_wr.size() > 0) ? got_wr[0] : 16'hxxxx;
                n_cmp++; if (w !== exp_w) begin n_bad++; $display("FAIL rnd%0d_wr got=%h exp=%h", t, w, exp_w); end
            end
            if (id != 8'h42 && id != 8'h43) begin
                n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_ignore_oe got=%b exp=0", t, oe_seen); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 8'($urandom);
            model_mem[i] = mem[i];
        end
        oe_seen = 1'b0;
        cur_sub = 8'h00;
        test_reset;
        test_write_100k;
        test_wrong_id;
        test_read;
        test_simul_release;
        test_timeout;
        test_reset_mid_read;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish within budget");
        $fatal(1);
    end

endmodule
